// File: rtl/pool_wb_serializer.sv
// rtl/pool_wb_serializer.sv - buffers pooled vectors and serializes them into write bursts
//
// Purpose:
//    Takes channel-wide pooled result vectors (one-cycle result_en pulse),
//    holds up to two in a FIFO and writes each one out as
//    channel_size/burst_len fixed-length bursts on the write-address /
//    write-data channels. The word pointer advances contiguously across
//    vectors.
//
// Ports:
//    clk, rst_n            clock, asynchronous active-low reset
//    result, result_en     pooled vector input and its valid pulse
//    base_addr(_en)        word address load, honoured only while idle
//    awaddr/awlen/awuser_* write-address payload
//    awvalid/awready       write-address handshake
//    wdata/wstrb/wlast     write-data payload
//    wvalid/wready         write-data handshake
//    vec_done              pulse after the last word of a vector is accepted
//    busy                  FSM active or FIFO holding data
//    overflow              sticky, a vector arrived with no room and was lost
module pool_wb_serializer #(
   parameter int         width        = 32,
   parameter int         channel_size = 64,
   parameter int         burst_len    = 16,
   parameter logic [3:0] user_id      = 4'h2
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [channel_size*width-1:0] result,
   input  logic                          result_en,
   input  logic [27:0]                   base_addr,
   input  logic                          base_addr_en,
   output logic [27:0]                   awaddr,
   output logic [3:0]                    awlen,
   output logic [3:0]                    awuser_id,
   output logic                          awuser_ap,
   output logic                          awvalid,
   input  logic                          awready,
   output logic [width-1:0]              wdata,
   output logic [width/8-1:0]            wstrb,
   output logic                          wvalid,
   output logic                          wlast,
   input  logic                          wready,
   output logic                          vec_done,
   output logic                          busy,
   output logic                          overflow
);

   localparam int nb     = channel_size / burst_len;
   localparam int ww     = (burst_len > 1) ? $clog2(burst_len) : 1;
   localparam int bw     = (nb > 1) ? $clog2(nb) : 1;
   localparam int idx_w  = (channel_size > 1) ? $clog2(channel_size) : 1;
   localparam int vec_w  = channel_size * width;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_AW   = 2'd1,
      S_W    = 2'd2
   } state_t;

   // FIFO storage and bookkeeping
   logic [vec_w-1:0] r_mem [2];
   logic             r_wr_sel;
   logic             r_rd_sel;
   logic [1:0]       r_count;
   logic             r_avail;

   // control state
   state_t           r_state;
   logic [bw-1:0]    r_b;
   logic [ww-1:0]    r_w;
   logic [27:0]      r_ptr;

   // registered outputs
   logic             r_awvalid;
   logic             r_wvalid;
   logic             r_wlast;
   logic [width/8-1:0] r_wstrb;
   logic             r_vec_done;
   logic             r_busy;
   logic             r_overflow;

   // next-state / combinational helpers
   state_t           w_next_state;
   logic [bw-1:0]    w_next_b;
   logic [ww-1:0]    w_next_w;
   logic             w_last_word;
   logic             w_burst_end;
   logic             w_pop;
   logic             w_push;
   logic             w_drop;
   logic [1:0]       w_count_next;
   logic [idx_w-1:0] w_idx;
   logic [vec_w-1:0] w_head;

   always_comb begin
      w_next_state = r_state;
      w_next_b     = r_b;
      w_next_w     = r_w;
      w_burst_end  = 1'b0;
      w_pop        = 1'b0;
      w_last_word  = (r_w == ww'(burst_len - 1));
      case (r_state)
         S_IDLE: begin
            if (r_avail) begin
               w_next_state = S_AW;
               w_next_b     = '0;
               w_next_w     = '0;
            end
         end
         S_AW: begin
            if (awready) begin
               w_next_state = S_W;
            end
         end
         S_W: begin
            if (wready) begin
               if (w_last_word) begin
                  w_burst_end = 1'b1;
                  w_next_w    = '0;
                  if (r_b != bw'(nb - 1)) begin
                     w_next_b     = r_b + 1'b1;
                     w_next_state = S_AW;
                  end else begin
                     w_pop        = 1'b1;
                     w_next_state = S_IDLE;
                  end
               end else begin
                  w_next_w = r_w + 1'b1;
               end
            end
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   // A full FIFO still accepts a vector in the cycle its head is popped.
   assign w_push = result_en && ((r_count != 2'd2) || w_pop);
   assign w_drop = result_en && (r_count == 2'd2) && !w_pop;

   always_comb begin
      w_count_next = r_count;
      case ({w_push, w_pop})
         2'b10:   w_count_next = r_count + 2'd1;
         2'b01:   w_count_next = r_count - 2'd1;
         default: w_count_next = r_count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_sel] <= result;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_sel <= 1'b0;
         r_rd_sel <= 1'b0;
         r_count  <= 2'd0;
         r_avail  <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_sel <= ~r_wr_sel;
         end
         if (w_pop) begin
            r_rd_sel <= ~r_rd_sel;
         end
         r_count <= w_count_next;
         // The FSM sees a new vector one cycle after it is written, but
         // sees a pop immediately so it never restarts on an empty FIFO.
         r_avail <= (r_count != 2'd0) && !(w_pop && (r_count == 2'd1));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_b        <= '0;
         r_w        <= '0;
         r_ptr      <= '0;
         r_awvalid  <= 1'b0;
         r_wvalid   <= 1'b0;
         r_wlast    <= 1'b0;
         r_wstrb    <= '0;
         r_vec_done <= 1'b0;
         r_busy     <= 1'b0;
         r_overflow <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_b     <= w_next_b;
         r_w     <= w_next_w;
         if ((r_state == S_IDLE) && base_addr_en) begin
            r_ptr <= base_addr;
         end else if (w_burst_end) begin
            r_ptr <= r_ptr + 28'(burst_len);
         end
         r_awvalid  <= (w_next_state == S_AW);
         r_wvalid   <= (w_next_state == S_W);
         r_wlast    <= (w_next_state == S_W) && (w_next_w == ww'(burst_len - 1));
         r_wstrb    <= (w_next_state == S_W) ? '1 : '0;
         r_vec_done <= w_pop;
         r_busy     <= (w_next_state != S_IDLE) || (w_count_next != 2'd0);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   // Word select from the head entry: burst index * burst_len + word index.
   assign w_head = r_mem[r_rd_sel];
   assign w_idx  = idx_w'(r_b) * idx_w'(burst_len) + idx_w'(r_w);
   assign wdata  = w_head[w_idx*width +: width];

   // awaddr is the pointer register itself; it only moves in W, so it is
   // stable for the whole address phase.
   assign awaddr    = r_ptr;
   assign awlen     = 4'(burst_len - 1);
   assign awuser_id = user_id;
   assign awuser_ap = 1'b1;
   assign awvalid   = r_awvalid;
   assign wvalid    = r_wvalid;
   assign wlast     = r_wlast;
   assign wstrb     = r_wstrb;
   assign vec_done  = r_vec_done;
   assign busy      = r_busy;
   assign overflow  = r_overflow;

endmodule
